// File: rtl/fpu_requester_if.sv
// Operation encoding shared by the requester, its FPU and its consumer, plus the
// bundle of command, FPU-side and response signals.
package fpu_requester_pkg;
    typedef enum logic [1:0] {
        FPU_ADD = 2'd0,
        FPU_SUB = 2'd1,
        FPU_MUL = 2'd2,
        FPU_DIV = 2'd3
    } fpuOp_t;
endpackage

interface fpu_requester_if #(
    parameter int BIT_WIDTH = 16
);
    import fpu_requester_pkg::*;

    logic                 cmdValid;
    logic                 cmdReady;
    fpuOp_t               cmdOp;
    logic [BIT_WIDTH-1:0] cmdIn1;
    logic [BIT_WIDTH-1:0] cmdIn2;

    logic [BIT_WIDTH-1:0] fpuIn1;
    logic [BIT_WIDTH-1:0] fpuIn2;
    fpuOp_t               fpuOp;
    logic [BIT_WIDTH-1:0] fpuOut;
    logic [3:0]           fpuCondCodes;

    logic                 rspValid;
    logic                 rspReady;
    logic [BIT_WIDTH-1:0] rspResult;
    logic [3:0]           rspCondCodes;
    logic                 rspErr;
    logic [3:0]           rspTag;

    // The requester block itself.
    modport slave (
        input  cmdValid, cmdOp, cmdIn1, cmdIn2, fpuOut, fpuCondCodes, rspReady,
        output cmdReady, fpuIn1, fpuIn2, fpuOp,
        output rspValid, rspResult, rspCondCodes, rspErr, rspTag
    );

    // The surrounding environment: command source, FPU and response consumer.
    modport master (
        output cmdValid, cmdOp, cmdIn1, cmdIn2, fpuOut, fpuCondCodes, rspReady,
        input  cmdReady, fpuIn1, fpuIn2, fpuOp,
        input  rspValid, rspResult, rspCondCodes, rspErr, rspTag
    );
endinterface

// File: rtl/fpu_requester.sv
// Single-outstanding FPU requester: accepts one command, drives it to a fixed-latency
// FPU, captures the result and holds it as a tagged response until consumed.
module fpu_requester
    import fpu_requester_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int LATENCY   = 1
) (
    input  logic           clock,
    input  logic           reset_L,
    fpu_requester_if.slave bus,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t               state_q, state_d;
    logic [2:0]           waitCnt_q, waitCnt_d;
    fpuOp_t               op_q, op_d;
    logic [BIT_WIDTH-1:0] in1_q, in1_d;
    logic [BIT_WIDTH-1:0] in2_q, in2_d;
    logic [BIT_WIDTH-1:0] result_q, result_d;
    logic [3:0]           cc_q, cc_d;
    logic                 err_q, err_d;
    logic [3:0]           tag_q, tag_d;

    always_comb begin
        // NOTE: every next-state signal takes its register value first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        op_d      = op_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        result_d  = result_q;
        cc_d      = cc_q;
        err_d     = err_q;
        tag_d     = tag_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmdValid) begin
                    op_d  = bus.cmdOp;
                    in1_d = bus.cmdIn1;
                    in2_d = bus.cmdIn2;
                    if (bus.cmdOp == FPU_ADD || bus.cmdOp == FPU_SUB) begin
                        waitCnt_d = LAT;
                        err_d     = 1'b0;
                        state_d   = EXEC;
                    end else begin
                        // Unsupported ops never touch the FPU; answer with an error at once.
                        result_d = '0;
                        cc_d     = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                waitCnt_d = waitCnt_q - 3'd1;
                if (waitCnt_q == 3'd1) begin
                    result_d = bus.fpuOut;
                    cc_d     = bus.fpuCondCodes;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rspReady) begin
                    tag_d   = tag_q + 4'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            op_q      <= FPU_ADD;
            in1_q     <= '0;
            in2_q     <= '0;
            result_q  <= '0;
            cc_q      <= '0;
            err_q     <= 1'b0;
            tag_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            op_q      <= op_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            result_q  <= result_d;
            cc_q      <= cc_d;
            err_q     <= err_d;
            tag_q     <= tag_d;
        end
    end

    assign bus.cmdReady     = (state_q == IDLE);
    assign bus.rspValid     = (state_q == RESP);
    assign busy             = (state_q != IDLE);
    assign bus.fpuIn1       = in1_q;
    assign bus.fpuIn2       = in2_q;
    assign bus.fpuOp        = op_q;
    assign bus.rspResult    = result_q;
    assign bus.rspCondCodes = cc_q;
    assign bus.rspErr       = err_q;
    assign bus.rspTag       = tag_q;
endmodule
